// File: rtl/ts_fir_sequencer.sv
// ts_fir_sequencer: phase/accumulator/output-load sequencer for a time-shared symmetric FIR,
// with sample-boundary coefficient bank swap and sticky overrun detection.
module ts_fir_sequencer #(
    parameter int PHASES   = 4,
    parameter int PW       = 2,
    parameter int PIPE_LAT = 2
) (
    input  logic          sys_clk,
    input  logic          reset_n,
    input  logic          sam_clk_en,
    input  logic          en,
    input  logic          bank_req,
    input  logic          bank_sel_in,
    output logic [PW-1:0] phase,
    output logic          acc_clr,
    output logic          acc_en,
    output logic          y_load,
    output logic          coef_bank,
    output logic          bank_ack,
    output logic          busy,
    output logic          overrun
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [PW-1:0] LAST = PW'(PHASES - 1);

    state_t          state_q, state_d;
    logic [PW-1:0]   ph_q, ph_d;
    logic [PIPE_LAT:0] sv_q, sv_d, fs_q, fs_d, ls_q, ls_d;
    logic            coef_bank_q, coef_bank_d;
    logic            bank_ack_q, bank_ack_d;
    logic            overrun_q, overrun_d;
    logic            run, last, accept;

    always_comb begin
        run         = state_q == RUN;
        last        = ph_q == LAST;
        accept      = sam_clk_en && en && (!run || last);
        state_d     = state_q;
        ph_d        = ph_q;
        if (accept) begin
            state_d = RUN;
            ph_d    = '0;
        end else if (run) begin
            state_d = last ? IDLE : RUN;
            ph_d    = last ? '0 : ph_q + PW'(1);
        end
        // Tags enter stage 0 one cycle after the slot is presented on phase
        sv_d        = {sv_q[PIPE_LAT-1:0], run};
        fs_d        = {fs_q[PIPE_LAT-1:0], run && ph_q == '0};
        ls_d        = {ls_q[PIPE_LAT-1:0], run && last};
        coef_bank_d = (accept && bank_req) ? bank_sel_in : coef_bank_q;
        bank_ack_d  = accept && bank_req;
        overrun_d   = en && (overrun_q || (sam_clk_en && run && !last));
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            ph_q        <= '0;
            sv_q        <= '0;
            fs_q        <= '0;
            ls_q        <= '0;
            coef_bank_q <= 1'b0;
            bank_ack_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ph_q        <= ph_d;
            sv_q        <= sv_d;
            fs_q        <= fs_d;
            ls_q        <= ls_d;
            coef_bank_q <= coef_bank_d;
            bank_ack_q  <= bank_ack_d;
            overrun_q   <= overrun_d;
        end
    end

    assign phase     = run ? ph_q : '0;
    assign acc_en    = sv_q[PIPE_LAT-1];
    assign acc_clr   = fs_q[PIPE_LAT-1];
    assign y_load    = ls_q[PIPE_LAT];
    assign coef_bank = coef_bank_q;
    assign bank_ack  = bank_ack_q;
    assign busy      = run || (|sv_q);
    assign overrun   = overrun_q;
endmodule

// File: tb/tb_ts_fir_sequencer.sv
// tb_ts_fir_sequencer: directed scenarios; expected strobe events are queued by the stimulus
// and popped by a monitor each time the DUT raises the corresponding output.
module tb_ts_fir_sequencer;
    typedef struct {int c; int v;} ev_t;

    logic       sys_clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       sam_clk_en = 1'b0;
    logic       en = 1'b1;
    logic       bank_req = 1'b0;
    logic       bank_sel_in = 1'b0;
    logic [1:0] phase;
    logic       acc_clr, acc_en, y_load, coef_bank, bank_ack, busy, overrun;

    int   cyc = 0;
    int   base = 0;
    int   ntests = 0;
    int   nfail = 0;
    ev_t  q_y[$], q_clr[$], q_en[$], q_ack[$], q_busy[$];
    ev_t  mon_e;
    ev_t  none_e = '{-1000, 0};

    ts_fir_sequencer #(.PHASES(4), .PW(2), .PIPE_LAT(2)) dut (
        .sys_clk(sys_clk), .reset_n(reset_n), .sam_clk_en(sam_clk_en), .en(en),
        .bank_req(bank_req), .bank_sel_in(bank_sel_in), .phase(phase), .acc_clr(acc_clr),
        .acc_en(acc_en), .y_load(y_load), .coef_bank(coef_bank), .bank_ack(bank_ack),
        .busy(busy), .overrun(overrun)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string nm, input ev_t e, input int v);
        ntests++;
        if (e.c != cyc || e.v != v) begin
            nfail++;
            $display("FAIL %s: seen cycle %0d value %0d, expected cycle %0d value %0d",
                     nm, cyc - base, v, e.c - base, e.v);
        end
    endtask

    task automatic cmp(input string nm, input int got, input int exp);
        ntests++;
        if (got != exp) begin
            nfail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc - base, got, exp);
        end
    endtask

    always @(negedge sys_clk) begin
        if (y_load) begin
            if (q_y.size() != 0) mon_e = q_y.pop_front(); else mon_e = none_e;
            check("y_load", mon_e, 1);
        end
        if (acc_clr) begin
            if (q_clr.size() != 0) mon_e = q_clr.pop_front(); else mon_e = none_e;
            check("acc_clr", mon_e, 1);
        end
        if (acc_en) begin
            if (q_en.size() != 0) mon_e = q_en.pop_front(); else mon_e = none_e;
            check("acc_en", mon_e, 1);
        end
        if (bank_ack) begin
            if (q_ack.size() != 0) mon_e = q_ack.pop_front(); else mon_e = none_e;
            check("bank_ack/coef_bank", mon_e, int'(coef_bank));
        end
        if (busy) begin
            if (q_busy.size() != 0) mon_e = q_busy.pop_front(); else mon_e = none_e;
            check("busy/phase", mon_e, int'(phase));
        end
    end

    task automatic go(input int c);
        while (cyc < base + c) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic at(input int c);
        go(c);
        @(negedge sys_clk);
        #1;
    endtask

    task automatic strobe(input int c);
        go(c);
        sam_clk_en = 1'b1;
        go(c + 1);
        sam_clk_en = 1'b0;
    endtask

    task automatic push_run(input int t);
        for (int i = 0; i < 4; i++) q_busy.push_back('{base + t + 1 + i, i});
    endtask

    task automatic push_drain(input int a, input int b);
        for (int c = a; c <= b; c++) q_busy.push_back('{base + c, 0});
    endtask

    task automatic push_acc(input int t);
        q_clr.push_back('{base + t + 3, 1});
        for (int i = 0; i < 4; i++) q_en.push_back('{base + t + 3 + i, 1});
        q_y.push_back('{base + t + 7, 1});
    endtask

    task automatic drained(input string nm);
        ntests++;
        if (q_y.size() + q_clr.size() + q_en.size() + q_ack.size() + q_busy.size() != 0) begin
            nfail++;
            $display("FAIL %s: missing events y=%0d clr=%0d en=%0d ack=%0d busy=%0d", nm,
                     q_y.size(), q_clr.size(), q_en.size(), q_ack.size(), q_busy.size());
            q_y.delete(); q_clr.delete(); q_en.delete(); q_ack.delete(); q_busy.delete();
        end
    endtask

    task automatic zero_outputs(input string nm);
        cmp(nm, int'({phase, acc_clr, acc_en, y_load, coef_bank, bank_ack, busy, overrun}), 0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        sam_clk_en = 1'b0;
        en = 1'b1;
        bank_req = 1'b0;
        bank_sel_in = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        zero_outputs("reset outputs");
        reset_n = 1'b1;
        base = cyc;
    endtask

    task automatic scen_normal();
        push_run(10); push_drain(15, 17); push_acc(10);
        strobe(10);
        at(18);
        cmp("busy after drain", int'(busy), 0);
        at(25);
        drained("single sample");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        do_reset();
        scen_normal();

        // back-to-back samples, second one carrying a same-cycle bank request
        do_reset();
        push_run(10); push_run(14); push_drain(19, 21); push_acc(10); push_acc(14);
        q_ack.push_back('{base + 15, 1});
        strobe(10);
        go(14);
        sam_clk_en = 1'b1; bank_req = 1'b1; bank_sel_in = 1'b1;
        go(15);
        sam_clk_en = 1'b0; bank_req = 1'b0;
        at(21);
        cmp("overrun back-to-back", int'(overrun), 0);
        at(26);
        drained("back-to-back");

        // early strobe sets sticky overrun, cleared by en=0
        do_reset();
        push_run(10); push_drain(15, 17); push_acc(10);
        strobe(10);
        go(12);
        sam_clk_en = 1'b1;
        at(12);
        cmp("overrun before", int'(overrun), 0);
        go(13);
        sam_clk_en = 1'b0;
        at(13);
        cmp("overrun set", int'(overrun), 1);
        at(19);
        cmp("overrun sticky", int'(overrun), 1);
        go(20);
        en = 1'b0;
        at(21);
        cmp("overrun cleared", int'(overrun), 0);
        en = 1'b1;
        at(25);
        drained("overrun");

        // bank request held from cycle 5, applied at accept 10
        do_reset();
        push_run(10); push_drain(15, 17); push_acc(10);
        q_ack.push_back('{base + 11, 1});
        go(5);
        bank_req = 1'b1; bank_sel_in = 1'b1;
        go(10);
        sam_clk_en = 1'b1;
        at(10);
        cmp("coef_bank before accept", int'(coef_bank), 0);
        go(11);
        sam_clk_en = 1'b0; bank_req = 1'b0;
        at(13);
        cmp("coef_bank after swap", int'(coef_bank), 1);
        at(25);
        drained("bank swap");

        // reset mid-sequence, then a clean sequence
        do_reset();
        q_busy.push_back('{base + 11, 0});
        q_busy.push_back('{base + 12, 1});
        strobe(10);
        go(13);
        reset_n = 1'b0;
        #1;
        zero_outputs("async reset mid-sequence");
        go(20);
        drained("aborted sequence");
        reset_n = 1'b1;
        base = cyc;
        scen_normal();

        // en dropped mid-sequence: sequence completes, later strobe ignored
        do_reset();
        push_run(10); push_drain(15, 17); push_acc(10);
        strobe(10);
        go(12);
        en = 1'b0;
        strobe(20);
        at(21);
        cmp("busy with en=0", int'(busy), 0);
        at(22);
        cmp("busy with en=0 later", int'(busy), 0);
        at(25);
        drained("en low");
        en = 1'b1;

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule

// File: doc/ts_fir_sequencer.md
# ts_fir_sequencer

Control sequencer for the 4:1 time-shared symmetric FIR datapath (51 folded tap pairs on 13 multipliers). On each accepted `sam_clk_en` it steps the multiplier-input/coefficient phase select through all `PHASES` slots. It issues accumulator clear/enable and output-load strobes, delayed to match the multiplier pipeline, and swaps coefficient banks only on sample boundaries. It sits beside the filter datapath and replaces the datapath's free-running phase counter.

## Interface
- `PHASES`, 4: time-share factor; sys_clk cycles of phase sequencing per sample (≥2, power of two).
- `PW`, 2: width of `phase`, equals log2(`PHASES`).
- `PIPE_LAT`, 2: sys_clk cycles from `phase` presentation to the product at the accumulator input (≥1).

Ports:
- `sys_clk`  in  1  system clock; all state updates on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `sam_clk_en`  in  1  sample strobe, one sys_clk wide; requests one filter sequence.
- `en`  in  1  sequencer enable; gates acceptance of new samples only.
- `bank_req`  in  1  coefficient-bank change request; level, held until `bank_ack`.
- `bank_sel_in`  in  1  requested bank; stable while `bank_req`=1.
- `phase`  out  PW  mux/coefficient phase select for the datapath.
- `acc_clr`  out  1  accumulator loads product (no add) this cycle.
- `acc_en`  out  1  accumulator adds product this cycle (asserted with `acc_clr` on the first slot).
- `y_load`  out  1  output register captures accumulator.
- `coef_bank`  out  1  active coefficient bank.
- `bank_ack`  out  1  one-cycle pulse: bank change applied.
- `busy`  out  1  a sequence is in flight (phase stepping or delay line non-empty).
- `overrun`  out  1  sticky: a sample arrived before the previous phase sequence finished.

## Operation
- FSM states: IDLE, RUN. Phase counter `ph` of PW bits.
- Accept condition: `sam_clk_en`=1 and `en`=1 and (state=IDLE, or state=RUN with `ph`=PHASES-1).
- On accept: next cycle state=RUN, `ph`=0. `ph` then increments each cycle.
- In RUN with `ph`=PHASES-1 and no accept: next state=IDLE, `ph` holds 0.
- `phase` = `ph` while in RUN, otherwise 0.
- Delay line of `PIPE_LAT`+1 stages carries two tags: slot-valid and first-slot.
  - `acc_en` = slot-valid delayed `PIPE_LAT` cycles.
  - `acc_clr` = first-slot delayed `PIPE_LAT` cycles.
  - `y_load` = last-slot tag delayed `PIPE_LAT`+1 cycles.
- `busy` = (state=RUN) OR any delay-line stage valid.
- Overrun: `sam_clk_en`=1 while in RUN with `ph`≠PHASES-1.
  - `overrun` is set and the strobe is ignored; the current sequence continues unchanged.
  - `overrun` clears only on reset, or on a cycle with `en`=0.
- `en` falling mid-sequence: the in-flight sequence and its drain complete normally. No new sample is accepted while `en`=0.
- Bank swap:
  - A pending `bank_req` is applied on the first cycle of the next accepted sequence (`ph`=0): `coef_bank`←`bank_sel_in`, and `bank_ack`=1 for that one cycle.
  - Never applied mid-sequence.
  - `bank_req` asserted with `bank_sel_in`=`coef_bank` still completes the handshake; the bank is unchanged.
  - After `bank_ack` the requester drops `bank_req` within 1 cycle. Holding `bank_req` longer re-applies at the following sample, which is harmless.

## Timing
- Reset (async assert, sync release): state=IDLE, `ph`=0, delay line cleared. Every output is 0: `phase`, `acc_clr`, `acc_en`, `y_load`, `coef_bank`, `bank_ack`, `busy`, `overrun`.
- Reset mid-sequence aborts it immediately; no `y_load` follows.
- Accept at cycle T:
  - `phase` = 0..PHASES-1 on T+1..T+PHASES.
  - `acc_clr`=1 at T+1+PIPE_LAT.
  - `acc_en`=1 on T+1+PIPE_LAT..T+PHASES+PIPE_LAT.
  - `y_load`=1 at T+PHASES+PIPE_LAT+1.
  - `busy`=1 on T+1..T+PHASES+PIPE_LAT+1.
- Back-to-back samples every `PHASES` cycles are legal. The next sequence's `acc_clr` may coincide with the previous `y_load`. In that cycle `y_load` captures the pre-clear accumulator value.
- `sam_clk_en` and `bank_req` first asserted in the same cycle: the bank is applied at that accept (`bank_ack` at T+1).

## Test plan
- Reset, then `en`=1, `sam_clk_en` at cycle 10 (PHASES=4, PIPE_LAT=2) -> `phase` 0,1,2,3 on 11–14; `acc_clr` at 13; `acc_en` on 13–16; `y_load` at 17; `busy` on 11–17.
- `sam_clk_en` at 10 and 14 -> second `phase`=0 at 15; `y_load` at 17 and 21; `acc_clr` at 13 and 17; `overrun`=0.
- `sam_clk_en` at 10 and 12 -> `overrun`=1 from 13 and stays set; a single `y_load` at 17; `en`=0 at 20 clears `overrun` at 21.
- `bank_req`=1, `bank_sel_in`=1 at cycle 5, `sam_clk_en` at 10 -> `coef_bank` 0→1 and `bank_ack` pulse at 11; no change before 11.
- `reset_n` low at cycle 13 during a sequence -> all outputs 0 immediately; no `y_load` at 17; next accept after release behaves as in scenario 1.
- `en`=0 at cycle 12 after accept at 10 -> sequence finishes (`y_load` at 17); `sam_clk_en` at 20 is ignored and `busy` stays 0.
